// File: rtl/ikari_arb_pkg.sv
// Shared types and constants for the CPU ROM-port arbiter.
package ikari_arb_pkg;

  localparam int unsigned NREQ        = 3;
  localparam int unsigned TIMER_W     = 8;
  localparam int unsigned STALL_CNT_W = 16;

  localparam logic [1:0] REQ_A   = 2'd0;
  localparam logic [1:0] REQ_B   = 2'd1;
  localparam logic [1:0] REQ_SND = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  // Round-robin successor; the unreachable id 3 behaves like 2.
  function automatic logic [1:0] next_req(input logic [1:0] id);
    case (id)
      REQ_A:   next_req = REQ_B;
      REQ_B:   next_req = REQ_SND;
      default: next_req = REQ_A;
    endcase
  endfunction

endpackage

// File: rtl/ikari_arb_latch.sv
// One-entry ROM read latch for a single CPU: hit compare, stall, and
// (when IKARI_ARB_STATS_EN is defined) a saturating dropped-enable counter.
module ikari_arb_latch
  import ikari_arb_pkg::*;
#(
  parameter int unsigned AW = 17,
  parameter int unsigned DW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_rd,
  input  logic [AW-1:0] i_addr,
  input  logic          i_fill,
  input  logic          i_clr,
  input  logic [AW-1:0] i_fill_addr,
  input  logic [DW-1:0] i_fill_data,
  output logic          o_stall_c,
  output logic [DW-1:0] o_data
`ifdef IKARI_ARB_STATS_EN
  ,
  input  logic                   i_cen,
  output logic [STALL_CNT_W-1:0] o_stall_cnt
`endif
);

  logic          r_valid;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic          w_hit;

  assign w_hit     = r_valid && (r_addr == i_addr);
  assign o_stall_c = i_rd & ~w_hit;
  assign o_data    = r_data;

  // Entry update: a fill always wins over an abandon-clear.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else if (i_fill) begin
      r_valid <= 1'b1;
      r_addr  <= i_fill_addr;
      r_data  <= i_fill_data;
    end else if (i_clr) begin
      r_valid <= 1'b0;
    end
  end

`ifdef IKARI_ARB_STATS_EN
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  assign o_stall_cnt = r_stall_cnt;

  // Count enable pulses swallowed by a stall, saturating at all-ones.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_stall_cnt <= '0;
    end else if (i_cen && o_stall_c && (r_stall_cnt != {STALL_CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
    end
  end
`endif

endmodule

// File: rtl/ikari_cen_rom_arbiter.sv
// Shares one SDRAM ROM read port between CPU A, CPU B and the sound CPU,
// gating each CPU clock enable while its fetch is outstanding.
// Optional macro IKARI_ARB_STATS_EN adds per-CPU dropped-enable counters.
module ikari_cen_rom_arbiter
  import ikari_arb_pkg::*;
#(
  parameter int unsigned AW      = 17,
  parameter int unsigned DW      = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_pause,
  input  logic [2:0]      i_cen,
  input  logic [2:0]      i_rd,
  input  logic [AW-1:0]   i_addr0,
  input  logic [AW-1:0]   i_addr1,
  input  logic [AW-1:0]   i_addr2,
  output logic [2:0]      o_cen,
  output logic [DW-1:0]   o_data0,
  output logic [DW-1:0]   o_data1,
  output logic [DW-1:0]   o_data2,
  output logic            o_mem_req,
  output logic [AW+1:0]   o_mem_addr,
  input  logic            i_mem_valid,
  input  logic [DW-1:0]   i_mem_data,
  output logic            o_timeout
`ifdef IKARI_ARB_STATS_EN
  ,
  output logic [STALL_CNT_W-1:0] o_stall_cnt0,
  output logic [STALL_CNT_W-1:0] o_stall_cnt1,
  output logic [STALL_CNT_W-1:0] o_stall_cnt2
`endif
);

  arb_state_e          r_state, w_state_nxt;
  logic [1:0]          r_grant, w_grant_nxt;
  logic [AW-1:0]       r_addr, w_addr_nxt;
  logic [1:0]          r_ptr, w_ptr_nxt;
  logic [TIMER_W-1:0]  r_timer, w_timer_nxt, w_timer_inc;
  logic                r_timeout, w_timeout_nxt;
  logic                r_mem_req, w_mem_req_nxt;
  logic [AW+1:0]       r_mem_addr, w_mem_addr_nxt;

  logic [AW-1:0]       w_req_addr [NREQ];
  logic [DW-1:0]       w_req_data [NREQ];
  logic [NREQ-1:0]     w_stall, w_fill, w_clr;
  logic                w_found, w_expire;
  logic [1:0]          w_sel, w_scan;

  assign w_req_addr[0] = i_addr0;
  assign w_req_addr[1] = i_addr1;
  assign w_req_addr[2] = i_addr2;
  assign o_data0       = w_req_data[0];
  assign o_data1       = w_req_data[1];
  assign o_data2       = w_req_data[2];

  assign o_cen      = i_cen & ~w_stall & {NREQ{~i_pause}};
  assign o_mem_req  = r_mem_req;
  assign o_mem_addr = r_mem_addr;
  assign o_timeout  = r_timeout;

  assign w_timer_inc = r_timer + TIMER_W'(1);
  assign w_expire    = (w_timer_inc == TIMER_W'(TIMEOUT));

`ifdef IKARI_ARB_STATS_EN
  logic [STALL_CNT_W-1:0] w_cnt [NREQ];
  assign o_stall_cnt0 = w_cnt[0];
  assign o_stall_cnt1 = w_cnt[1];
  assign o_stall_cnt2 = w_cnt[2];
`endif

  for (genvar g = 0; g < NREQ; g++) begin : g_req
    ikari_arb_latch #(.AW(AW), .DW(DW)) u_latch (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_rd        (i_rd[g]),
      .i_addr      (w_req_addr[g]),
      .i_fill      (w_fill[g]),
      .i_clr       (w_clr[g]),
      .i_fill_addr (r_addr),
      .i_fill_data (i_mem_data),
      .o_stall_c   (w_stall[g]),
      .o_data      (w_req_data[g])
`ifdef IKARI_ARB_STATS_EN
      ,
      .i_cen       (i_cen[g]),
      .o_stall_cnt (w_cnt[g])
`endif
    );
  end

  // Round-robin pick of the first stalled requester after the last one served.
  always_comb begin
    w_found = 1'b0;
    w_sel   = REQ_A;
    w_scan  = next_req(r_ptr);
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!w_found && w_stall[w_scan]) begin
        w_found = 1'b1;
        w_sel   = w_scan;
      end
      w_scan = next_req(w_scan);
    end
  end

  // State register plus registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_grant    <= REQ_A;
      r_addr     <= '0;
      r_ptr      <= REQ_SND;
      r_timer    <= '0;
      r_timeout  <= 1'b0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_addr     <= w_addr_nxt;
      r_ptr      <= w_ptr_nxt;
      r_timer    <= w_timer_nxt;
      r_timeout  <= w_timeout_nxt;
      r_mem_req  <= w_mem_req_nxt;
      r_mem_addr <= w_mem_addr_nxt;
    end
  end

  // Next-state logic: grant in IDLE, strobe in ISSUE, fill or abandon in WAIT.
  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_addr_nxt    = r_addr;
    w_ptr_nxt     = r_ptr;
    w_timer_nxt   = r_timer;
    w_timeout_nxt = r_timeout;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_grant_nxt = w_sel;
          w_addr_nxt  = w_req_addr[w_sel];
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_timer_nxt = '0;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        w_timer_nxt = w_timer_inc;
        if (i_mem_valid) begin
          w_ptr_nxt   = r_grant;
          w_state_nxt = ST_IDLE;
        end else if (w_expire) begin
          w_timeout_nxt = 1'b1;
          w_state_nxt   = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: memory strobe/address and latch fill/clear controls.
  always_comb begin
    w_mem_req_nxt  = 1'b0;
    w_mem_addr_nxt = r_mem_addr;
    w_fill         = '0;
    w_clr          = '0;
    case (r_state)
      ST_ISSUE: begin
        w_mem_req_nxt  = 1'b1;
        w_mem_addr_nxt = {r_grant, r_addr};
      end
      ST_WAIT: begin
        if (i_mem_valid) begin
          w_fill[r_grant] = 1'b1;
        end else if (w_expire) begin
          w_clr[r_grant] = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ikari_cen_rom_arbiter.sv
// Bench for the CPU ROM-port arbiter: behavioural model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ikari_cen_rom_arbiter;
  import ikari_arb_pkg::*;

  localparam int unsigned AW = 17;
  localparam int unsigned DW = 8;
  localparam int          TO = 255;

  logic          clk = 1'b0;
  logic          rst_n, pause, mvalid;
  logic [2:0]    cen, rd, o_cen;
  logic [AW-1:0] a0, a1, a2;
  logic [DW-1:0] mdata, d0, d1, d2;
  logic          mreq, tout;
  logic [AW+1:0] maddr;
`ifdef IKARI_ARB_STATS_EN
  logic [15:0]   c0, c1, c2;
`endif

  always #5 clk = ~clk;

  ikari_cen_rom_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_pause(pause), .i_cen(cen), .i_rd(rd),
    .i_addr0(a0), .i_addr1(a1), .i_addr2(a2), .o_cen(o_cen),
    .o_data0(d0), .o_data1(d1), .o_data2(d2), .o_mem_req(mreq),
    .o_mem_addr(maddr), .i_mem_valid(mvalid), .i_mem_data(mdata),
    .o_timeout(tout)
`ifdef IKARI_ARB_STATS_EN
    , .o_stall_cnt0(c0), .o_stall_cnt1(c1), .o_stall_cnt2(c2)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: per-CPU cached word, one outstanding fetch record.
  bit            m_known = 0;
  bit            m_v [3];
  logic [AW-1:0] m_a [3];
  logic [DW-1:0] m_d [3];
  int            m_cnt [3];
  bit            m_busy, m_issued, m_req, m_to;
  int            m_gnt, m_last, m_waited;
  logic [AW-1:0] m_fa;
  logic [AW+1:0] m_maddr;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] cur_addr(input int i);
    case (i)
      0:       return a0;
      1:       return a1;
      default: return a2;
    endcase
  endfunction

  function automatic bit m_stall(input int i);
    return rd[i] && !(m_v[i] && (m_a[i] == cur_addr(i)));
  endfunction

  task automatic model_check();
    logic [2:0] ec;
    if (!m_known) return;
    for (int i = 0; i < 3; i++) ec[i] = cen[i] && !m_stall(i) && !pause;
    chk("cen", o_cen, ec);
    chk("data0", d0, m_d[0]);
    chk("data1", d1, m_d[1]);
    chk("data2", d2, m_d[2]);
    chk("mem_req", mreq, m_req);
    chk("mem_addr", maddr, m_maddr);
    chk("timeout", tout, m_to);
`ifdef IKARI_ARB_STATS_EN
    chk("stall_cnt0", c0, m_cnt[0]);
    chk("stall_cnt1", c1, m_cnt[1]);
    chk("stall_cnt2", c2, m_cnt[2]);
`endif
  endtask

  task automatic model_step();
    bit new_req, found;
    int cand;
    if (!rst_n) begin
      m_known = 1; m_busy = 0; m_issued = 0; m_req = 0; m_to = 0;
      m_last = 2; m_maddr = '0; m_waited = 0;
      for (int i = 0; i < 3; i++) begin
        m_v[i] = 0; m_a[i] = '0; m_d[i] = '0; m_cnt[i] = 0;
      end
      return;
    end
    if (!m_known) return;
    for (int i = 0; i < 3; i++)
      if (cen[i] && m_stall(i) && m_cnt[i] < 65535) m_cnt[i]++;
    new_req = 0;
    if (!m_busy) begin
      found = 0;
      for (int k = 1; k <= 3; k++) begin
        cand = (m_last + k) % 3;
        if (!found && m_stall(cand)) begin
          found = 1; m_busy = 1; m_issued = 0; m_gnt = cand; m_fa = cur_addr(cand);
        end
      end
    end else if (!m_issued) begin
      new_req = 1; m_issued = 1; m_waited = 0;
      m_maddr = {2'(m_gnt), m_fa};
    end else begin
      m_waited++;
      if (mvalid) begin
        m_v[m_gnt] = 1; m_a[m_gnt] = m_fa; m_d[m_gnt] = mdata;
        m_last = m_gnt; m_busy = 0;
      end else if (m_waited == TO) begin
        m_to = 1; m_v[m_gnt] = 0; m_busy = 0;
      end
    end
    m_req = new_req;
  endtask

  // One clock: compare, advance model, move to next negedge; valid is a pulse.
  task automatic tick();
    #1;
    model_check();
    model_step();
    @(negedge clk);
    mvalid = 1'b0;
  endtask

  task automatic reset_dut();
    rst_n = 0; cen = 0; rd = 0; pause = 0; mvalid = 0;
    tick(); tick();
    rst_n = 1;
  endtask

  // Answer each fetch on its first wait cycle until nothing is stalled.
  task automatic serve(input int max_c, input logic [DW-1:0] dat);
    bit done = 0;
    for (int c = 0; c < max_c && !done; c++) begin
      done = !m_busy && !m_stall(0) && !m_stall(1) && !m_stall(2);
      if (m_busy && m_issued) begin mvalid = 1; mdata = dat; end
      tick();
    end
    chk("serve_done", {63'd0, m_busy}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int order[$];
    int due, t_to, t_rq;
    bit a_moved, silent;
    a0 = '0; a1 = '0; a2 = '0; mdata = '0;
    rst_n = 0; cen = 0; rd = 0; pause = 0; mvalid = 0;
    @(negedge clk);

    // Reset state and single request from CPU A.
    reset_dut();
    #1;
    chk("rst_data0", d0, 0); chk("rst_req", mreq, 0);
    chk("rst_maddr", maddr, 0); chk("rst_timeout", tout, 0); chk("rst_cen", o_cen, 0);
    a0 = 17'h01234; rd = 3'b001; cen = 3'b001;
    #1 chk("sr_cen_held", o_cen[0], 0); tick();
    #1 chk("sr_req_c1", mreq, 0); tick();
    #1 chk("sr_req_c2", mreq, 1); chk("sr_addr", maddr, {2'd0, 17'h01234}); tick();
    repeat (4) tick();
    mvalid = 1; mdata = 8'hA5; tick();
    #1 chk("sr_data", d0, 8'hA5); chk("sr_cen", o_cen[0], 1); tick();

    // Round robin: A, B, sound, then A again after it re-stalls.
    reset_dut();
    a0 = 17'h00100; a1 = 17'h00200; a2 = 17'h00300; rd = 3'b111; cen = 3'b111;
    due = -1; a_moved = 0;
    for (int c = 0; c < 80 && order.size() < 4; c++) begin
      #1;
      if (mreq) begin order.push_back(int'(maddr[AW+1:AW])); due = c + 2; end
      if (c == due) begin mvalid = 1; mdata = 8'(c + 8'h30); end
      tick();
      if (!a_moved && m_v[0]) begin a0 = 17'h00180; a_moved = 1; end
    end
    chk("rr_grant0", order.size() > 0 ? order[0] : -1, 0);
    chk("rr_grant1", order.size() > 1 ? order[1] : -1, 1);
    chk("rr_grant2", order.size() > 2 ? order[2] : -1, 2);
    chk("rr_grant3", order.size() > 3 ? order[3] : -1, 0);
    serve(40, 8'h66);

    // Valid on the last allowed wait cycle wins over the timeout.
    reset_dut();
    a1 = 17'h00BEE; rd = 3'b010; cen = 3'b010;
    repeat (256) tick();
    mvalid = 1; mdata = 8'h3C; tick();
    #1 chk("vw_timeout", tout, 0); chk("vw_data1", d1, 8'h3C); chk("vw_cen1", o_cen[1], 1);
    tick();

    // Timeout for CPU B: abandon after 255 wait cycles, then re-request.
    a1 = 17'h00BEF;
    t_to = -1; t_rq = -1;
    for (int c = 0; c < 400 && !(t_rq >= 0 && c > t_rq + 4); c++) begin
      #1;
      if (tout && t_to < 0) t_to = c;
      if (mreq && t_to >= 0 && t_rq < 0) begin
        t_rq = c;
        chk("to_reissue_id", maddr[AW+1:AW], 2'd1);
      end
      if (t_rq >= 0 && c == t_rq + 2) begin mvalid = 1; mdata = 8'h77; end
      tick();
    end
    chk("to_set_cycle", t_to, 257);
    chk("to_reissue_cycle", t_rq, 259);
    #1 chk("to_sticky", tout, 1); chk("to_fill", d1, 8'h77); tick();

    // Pause freezes all enables; an in-flight fetch still completes.
    reset_dut();
    a0 = 17'h00011; a1 = 17'h00022; a2 = 17'h00033; rd = 3'b111; cen = 3'b111;
    serve(60, 8'h42);
    pause = 1;
    #1 chk("pa_cen_all_hit", o_cen, 3'b000); tick();
    a2 = 17'h00333;
    serve(30, 8'h5A);
    #1 chk("pa_fill", d2, 8'h5A); chk("pa_cen_paused", o_cen, 3'b000);
    pause = 0;
    #1 chk("pa_cen_resume", o_cen, 3'b111); tick();

    // Address change while the fetch is waiting: old address fills, refetch.
    reset_dut();
    a0 = 17'h00010; rd = 3'b001; cen = 3'b001;
    tick(); tick();
    #1 chk("ac_req", mreq, 1); chk("ac_addr", maddr, {2'd0, 17'h00010}); tick();
    a0 = 17'h00020; tick();
    mvalid = 1; mdata = 8'h11; tick();
    #1 chk("ac_still_stalled", o_cen[0], 0); chk("ac_data", d0, 8'h11); tick();
    tick();
    #1 chk("ac_rereq", mreq, 1); chk("ac_readdr", maddr, {2'd0, 17'h00020}); tick();
    serve(20, 8'h22);

`ifdef IKARI_ARB_STATS_EN
    // Dropped-enable counter: ten pulses during a sound stall, then saturation.
    reset_dut();
    a2 = 17'h00777; rd = 3'b100;
    for (int k = 0; k < 20; k++) begin cen = (k % 2 == 0) ? 3'b100 : 3'b000; tick(); end
    cen = 0;
    #1 chk("st_cnt2_ten", c2, 10);
    force dut.g_req[2].u_latch.r_stall_cnt = 16'hFFFD;
    #1 release dut.g_req[2].u_latch.r_stall_cnt;
    m_cnt[2] = 16'hFFFD;
    cen = 3'b100;
    repeat (5) tick();
    #1 chk("st_cnt2_sat", c2, 16'hFFFF);
    cen = 0;
    serve(300, 8'h01);
`endif

    // Randomized traffic against the model.
    silent = 0;
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 599) != 0);
      pause = ($urandom_range(0, 15) == 0);
      cen   = 3'($urandom);
      rd    = 3'($urandom) | 3'($urandom);
      if ($urandom_range(0, 7) == 0) a0 = 17'h00400 + 17'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a1 = 17'h10800 + 17'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a2 = 17'h01C00 + 17'($urandom_range(0, 3));
      if ($urandom_range(0, 499) == 0) silent = !silent;
      if (m_busy && m_issued) mvalid = !silent && ($urandom_range(0, 3) == 0);
      else                    mvalid = ($urandom_range(0, 15) == 0);
      mdata = 8'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
